// File: rtl/hazard_scoreboard.sv
// Countdown scoreboard beside the ID stage: detects RAW, WAW and structural
// hazards for producers of any fixed or variable latency and counts stall cycles.
module hazard_scoreboard #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned LAT_W    = 3,
  parameter bit          FWD_EN   = 1'b1,
  parameter int unsigned WB_DIST  = 3,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_issue_valid,
  input  logic              i_issue_we,
  input  logic [ADDR_W-1:0] i_issue_rd,
  input  logic [LAT_W-1:0]  i_issue_lat,
  input  logic              i_issue_mc,
  input  logic [ADDR_W-1:0] i_id_rs1,
  input  logic [ADDR_W-1:0] i_id_rs2,
  input  logic              i_id_rs1_used,
  input  logic              i_id_rs2_used,
  input  logic              i_mc_busy,
  input  logic              i_wb_valid,
  input  logic [ADDR_W-1:0] i_wb_rd,
  input  logic              i_flush,
  output logic              o_hazard_stall,
  output logic              o_stall_raw,
  output logic              o_stall_waw,
  output logic              o_stall_struct,
  output logic [CNT_W-1:0]  o_stall_cycles
);

  localparam int unsigned     DEPTH   = 1 << ADDR_W;
  localparam logic [LAT_W-1:0] LAT_UNK = '1;
  localparam int unsigned     LAT_MAX = (1 << LAT_W) - 2;

  // Per-register remaining cycles and variable-latency pending flag.
  // Entries 0 and >= NUM_REGS are held at zero so they never look busy.
  logic [LAT_W-1:0] cnt_q [DEPTH];
  logic [DEPTH-1:0] unk_q;

  logic [DEPTH-1:0] busy;
  logic [LAT_W-1:0] load_val;
  logic             raw;
  logic             waw;
  logic             strc;
  logic             fire;
  logic             wr_en;
  logic             is_unk;

  // Countdown value loaded on issue; with no forwarding the consumer also
  // waits for the register-file write to become readable.
  always_comb begin
    int unsigned lv;
    lv = 0;
    if (i_issue_lat != '0) lv = 32'(i_issue_lat) - 1;
    if (!FWD_EN && WB_DIST > 1 && lv < WB_DIST - 1) lv = WB_DIST - 1;
    if (lv > LAT_MAX) lv = LAT_MAX;
    load_val = LAT_W'(lv);
  end

  // Busy vector and the three hazard causes.
  always_comb begin
    for (int unsigned r = 0; r < DEPTH; r++) begin
      busy[r] = (cnt_q[r] != '0) | unk_q[r];
    end
    raw  = (i_id_rs1_used & busy[i_id_rs1]) | (i_id_rs2_used & busy[i_id_rs2]);
    waw  = i_issue_we & (i_issue_rd != '0) &
           (unk_q[i_issue_rd] | (cnt_q[i_issue_rd] > load_val));
    strc = i_issue_mc & i_mc_busy;
  end

  assign o_stall_raw    = i_issue_valid & raw;
  assign o_stall_waw    = i_issue_valid & waw;
  assign o_stall_struct = i_issue_valid & strc;
  assign o_hazard_stall = o_stall_raw | o_stall_waw | o_stall_struct;

  assign fire   = i_issue_valid & ~o_hazard_stall & ~i_flush;
  assign wr_en  = fire & i_issue_we & (i_issue_rd != '0);
  assign is_unk = (i_issue_lat == LAT_UNK);

  // Scoreboard update: issue load beats decrement and writeback clear.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int unsigned r = 0; r < DEPTH; r++) begin
        cnt_q[r] <= '0;
      end
      unk_q <= '0;
    end else begin
      for (int unsigned r = 0; r < DEPTH; r++) begin
        if (r == 0 || r >= NUM_REGS) begin
          cnt_q[r] <= '0;
          unk_q[r] <= 1'b0;
        end else if (wr_en && i_issue_rd == ADDR_W'(r)) begin
          cnt_q[r] <= is_unk ? '0 : load_val;
          unk_q[r] <= is_unk;
        end else begin
          if (cnt_q[r] != '0) cnt_q[r] <= cnt_q[r] - LAT_W'(1);
          if (i_wb_valid && i_wb_rd == ADDR_W'(r)) unk_q[r] <= 1'b0;
        end
      end
    end
  end

  // Saturating stall-cycle performance counter.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_stall_cycles <= '0;
    end else if (o_hazard_stall && o_stall_cycles != '1) begin
      o_stall_cycles <= o_stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Three scoreboard configurations driven with shared stimulus and checked each
// cycle against a timestamp-based model (ready time per register).
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid, we, mc, mc_busy, rs1_used, rs2_used, wb_valid, flush;
  logic [4:0] rd, rs1, rs2, wb_rd;
  logic [2:0] lat;

  logic        stall [3];
  logic        raw_o [3];
  logic        waw_o [3];
  logic        str_o [3];
  logic [15:0] cyc0, cyc1;
  logic [3:0]  cyc2;

  int total = 0;
  int bad   = 0;

  // Model state: absolute cycle at which each register becomes readable.
  longint now = 0;
  longint ready_at [3][32];
  bit     unk_m    [3][32];
  longint stalls_m [3];
  bit     fwd_k    [3] = '{1'b1, 1'b0, 1'b1};
  longint cmax_k   [3] = '{65535, 65535, 15};

  always #5 clk = ~clk;

  hazard_scoreboard u0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_issue_valid(valid), .i_issue_we(we),
    .i_issue_rd(rd), .i_issue_lat(lat), .i_issue_mc(mc), .i_id_rs1(rs1),
    .i_id_rs2(rs2), .i_id_rs1_used(rs1_used), .i_id_rs2_used(rs2_used),
    .i_mc_busy(mc_busy), .i_wb_valid(wb_valid), .i_wb_rd(wb_rd), .i_flush(flush),
    .o_hazard_stall(stall[0]), .o_stall_raw(raw_o[0]), .o_stall_waw(waw_o[0]),
    .o_stall_struct(str_o[0]), .o_stall_cycles(cyc0));

  hazard_scoreboard #(.FWD_EN(1'b0), .WB_DIST(3)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_issue_valid(valid), .i_issue_we(we),
    .i_issue_rd(rd), .i_issue_lat(lat), .i_issue_mc(mc), .i_id_rs1(rs1),
    .i_id_rs2(rs2), .i_id_rs1_used(rs1_used), .i_id_rs2_used(rs2_used),
    .i_mc_busy(mc_busy), .i_wb_valid(wb_valid), .i_wb_rd(wb_rd), .i_flush(flush),
    .o_hazard_stall(stall[1]), .o_stall_raw(raw_o[1]), .o_stall_waw(waw_o[1]),
    .o_stall_struct(str_o[1]), .o_stall_cycles(cyc1));

  hazard_scoreboard #(.CNT_W(4)) u2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_issue_valid(valid), .i_issue_we(we),
    .i_issue_rd(rd), .i_issue_lat(lat), .i_issue_mc(mc), .i_id_rs1(rs1),
    .i_id_rs2(rs2), .i_id_rs1_used(rs1_used), .i_id_rs2_used(rs2_used),
    .i_mc_busy(mc_busy), .i_wb_valid(wb_valid), .i_wb_rd(wb_rd), .i_flush(flush),
    .o_hazard_stall(stall[2]), .o_stall_raw(raw_o[2]), .o_stall_waw(waw_o[2]),
    .o_stall_struct(str_o[2]), .o_stall_cycles(cyc2));

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint cyc_of(input int k);
    case (k)
      0:       return longint'(cyc0);
      1:       return longint'(cyc1);
      default: return longint'(cyc2);
    endcase
  endfunction

  // Cycles a consumer must wait after this issue, for configuration k.
  function automatic longint wait_of(input int k);
    longint l;
    l = (lat == 0) ? 0 : longint'(lat) - 1;
    if (!fwd_k[k] && l < 2) l = 2;
    if (l > 6) l = 6;
    return l;
  endfunction

  function automatic bit busy_m(input int k, input logic [4:0] r);
    if (r == 0) return 1'b0;
    return unk_m[k][r] || (ready_at[k][r] > now);
  endfunction

  task automatic model_eval(input int k, output bit e_raw, output bit e_waw,
                            output bit e_str);
    e_raw = valid && ((rs1_used && busy_m(k, rs1)) || (rs2_used && busy_m(k, rs2)));
    e_waw = valid && we && rd != 0 &&
            (unk_m[k][rd] || (ready_at[k][rd] - now > wait_of(k)));
    e_str = valid && mc && mc_busy;
  endtask

  task automatic model_update();
    bit r, w, s, st;
    for (int k = 0; k < 3; k++) begin
      model_eval(k, r, w, s);
      st = r | w | s;
      if (!rst_n) begin
        for (int i = 0; i < 32; i++) begin
          ready_at[k][i] = 0;
          unk_m[k][i]    = 1'b0;
        end
        stalls_m[k] = 0;
      end else begin
        if (st && stalls_m[k] < cmax_k[k]) stalls_m[k]++;
        if (wb_valid) unk_m[k][wb_rd] = 1'b0;
        if (valid && !st && !flush && we && rd != 0) begin
          if (lat == 3'd7) begin
            unk_m[k][rd]    = 1'b1;
            ready_at[k][rd] = now;
          end else begin
            unk_m[k][rd]    = 1'b0;
            ready_at[k][rd] = now + 1 + wait_of(k);
          end
        end
      end
    end
    now++;
  endtask

  // Inputs are set just after a negedge; check, then advance one clock.
  task automatic step();
    bit r, w, s;
    #1;
    for (int k = 0; k < 3; k++) begin
      model_eval(k, r, w, s);
      chk($sformatf("raw%0d", k),   raw_o[k], r);
      chk($sformatf("waw%0d", k),   waw_o[k], w);
      chk($sformatf("str%0d", k),   str_o[k], s);
      chk($sformatf("stall%0d", k), stall[k], r | w | s);
      chk($sformatf("cyc%0d", k),   cyc_of(k), stalls_m[k]);
    end
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    rst_n = 1'b1; valid = 1'b0; we = 1'b0; rd = '0; lat = '0; mc = 1'b0;
    mc_busy = 1'b0; rs1 = '0; rs2 = '0; rs1_used = 1'b0; rs2_used = 1'b0;
    wb_valid = 1'b0; wb_rd = '0; flush = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic issue(input logic [4:0] d, input logic [2:0] l);
    idle();
    valid = 1'b1; we = 1'b1; rd = d; lat = l;
  endtask

  task automatic consume(input logic [4:0] s1, input logic u1, input logic [4:0] s2,
                         input logic u2);
    idle();
    valid = 1'b1; rs1 = s1; rs1_used = u1; rs2 = s2; rs2_used = u2;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("reset_cyc", cyc0, 0);
    chk("reset_stall", stall[0], 0);

    // Load-use
    do_reset();
    issue(5'd5, 3'd2); step();
    consume(5'd5, 1'b1, 5'd0, 1'b0);
    repeat (4) step();
    chk("loaduse_cyc", cyc0, 1);
    chk("loaduse_nofwd_cyc", cyc1, 2);

    // Multi-cycle RAW, then rd=0 and unused rs2
    do_reset();
    issue(5'd7, 3'd4); step();
    consume(5'd0, 1'b0, 5'd7, 1'b1);
    repeat (6) step();
    chk("mcraw_cyc", cyc0, 3);
    do_reset();
    issue(5'd0, 3'd4); step();
    consume(5'd0, 1'b0, 5'd0, 1'b1); repeat (4) step();
    issue(5'd7, 3'd4); step();
    consume(5'd0, 1'b0, 5'd7, 1'b0); repeat (4) step();
    chk("norap_cyc", cyc0, 0);

    // Variable latency: wrong wb keeps stall, right wb releases next cycle
    do_reset();
    issue(5'd9, 3'd7); step();
    consume(5'd9, 1'b1, 5'd0, 1'b0); step();
    wb_valid = 1'b1; wb_rd = 5'd10; step();
    chk("unk_wrongwb", stall[0], 1);
    wb_rd = 5'd9; step();
    wb_valid = 1'b0; step();
    chk("unk_release", stall[0], 0);
    chk("unk_cyc", cyc0, 3);

    // WAW, then all three causes together
    do_reset();
    issue(5'd3, 3'd4); step();
    issue(5'd3, 3'd1); repeat (5) step();
    chk("waw_cyc", cyc0, 3);
    do_reset();
    issue(5'd3, 3'd4); step();
    issue(5'd3, 3'd1); mc = 1'b1; mc_busy = 1'b1; rs1 = 5'd3; rs1_used = 1'b1;
    #1;
    chk("all_raw", raw_o[0], 1);
    chk("all_waw", waw_o[0], 1);
    chk("all_str", str_o[0], 1);
    step();

    // Flush suppresses the entry
    do_reset();
    issue(5'd5, 3'd4); flush = 1'b1; step();
    consume(5'd5, 1'b1, 5'd0, 1'b0); repeat (3) step();
    chk("flush_cyc", cyc0, 0);

    // Reset with pending entries, then a stray wb
    issue(5'd9, 3'd7); step();
    issue(5'd6, 3'd6); step();
    do_reset();
    consume(5'd9, 1'b1, 5'd6, 1'b1); step();
    chk("rst_pend_stall", stall[0], 0);
    wb_valid = 1'b1; wb_rd = 5'd9; step();
    chk("rst_pend_cyc", cyc0, 0);

    // Saturation of the 4-bit counter
    do_reset();
    idle(); valid = 1'b1; mc = 1'b1; mc_busy = 1'b1;
    repeat (20) step();
    chk("sat_cyc4", cyc2, 15);
    chk("sat_cyc16", cyc0, 20);

    // Randomized traffic on a small register window
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst_n    = ($urandom_range(0, 299) != 0);
      valid    = ($urandom_range(0, 3) != 0);
      we       = ($urandom_range(0, 3) != 0);
      rd       = 5'($urandom_range(0, 7));
      lat      = 3'($urandom_range(0, 7));
      mc       = ($urandom_range(0, 3) == 0);
      mc_busy  = 1'($urandom_range(0, 1));
      rs1      = 5'($urandom_range(0, 7));
      rs2      = 5'($urandom_range(0, 7));
      rs1_used = 1'($urandom_range(0, 1));
      rs2_used = 1'($urandom_range(0, 1));
      wb_valid = ($urandom_range(0, 3) == 0);
      wb_rd    = 5'($urandom_range(0, 7));
      flush    = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
